// File: rtl/datapath_pkg.sv
// Shared constants for the datapath: data width and ALU operation codes.
package datapath_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a comes from Y, b from the bus, result is {hi, lo}.
// The signed divider exists only when DATAPATH_DIV_EN is defined; otherwise
// op 12 falls into the default arm and yields zero.
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [4:0]              shamt;
    logic signed [63:0]      a_ext;
    logic signed [63:0]      b_ext;
    logic signed [63:0]      prod;
    logic [2*DATA_WIDTH-1:0] a_dbl;
    logic [2*DATA_WIDTH-1:0] ror_full;
    logic [2*DATA_WIDTH-1:0] rol_full;

    assign shamt    = b[4:0];
    // Sign-extend to 64 bits so the low 64 bits of the product are the signed product.
    assign a_ext    = {{32{a[31]}}, a};
    assign b_ext    = {{32{b[31]}}, b};
    assign prod     = a_ext * b_ext;
    // Rotates via a doubled word: low half of {a,a}>>s, high half of {a,a}<<s.
    assign a_dbl    = {a, a};
    assign ror_full = a_dbl >> shamt;
    assign rol_full = a_dbl << shamt;

`ifdef DATAPATH_DIV_EN
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic signed [DATA_WIDTH-1:0] quot;
    logic signed [DATA_WIDTH-1:0] rem;

    assign a_s  = a;
    assign b_s  = b;
    assign quot = (b == '0) ? '1 : a_s / b_s;
    assign rem  = (b == '0) ? a_s : a_s % b_s;
`endif

    // Operation decode; hi stays zero except for mul and div.
    always_comb begin
        hi = '0;
        lo = '0;
        case (op)
            ALU_ADD:  lo = a + b;
            ALU_SUB:  lo = a - b;
            ALU_AND:  lo = a & b;
            ALU_OR:   lo = a | b;
            ALU_SHR:  lo = a >> shamt;
            ALU_SHRA: lo = $signed(a) >>> shamt;
            ALU_SHL:  lo = a << shamt;
            ALU_ROR:  lo = ror_full[DATA_WIDTH-1:0];
            ALU_ROL:  lo = rol_full[2*DATA_WIDTH-1:DATA_WIDTH];
            ALU_NEG:  lo = '0 - b;
            ALU_NOT:  lo = ~b;
            ALU_MUL: begin
                hi = prod[63:32];
                lo = prod[31:0];
            end
`ifdef DATAPATH_DIV_EN
            ALU_DIV: begin
                hi = rem;
                lo = quot;
            end
`endif
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: 16 GPRs plus PC, IR, MAR, MDR, Y, HI, LO, ZHI, ZLO.
// Optional feature macro: DATAPATH_DIV_EN enables the signed divider (op 12).
module datapath
    import datapath_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] RegisterImmediate,
    input  logic                  Read,
    input  logic [DATA_WIDTH-1:0] Mdatain,
    input  logic [3:0]            ALUop,
    input  logic [15:0]           Rin,
    input  logic [15:0]           Rout,
    input  logic                  PCin,
    input  logic                  MARin,
    input  logic                  IRin,
    input  logic                  Yin,
    input  logic                  MDRin,
    input  logic                  HIin,
    input  logic                  LOin,
    input  logic                  Zhighin,
    input  logic                  Zlowin,
    input  logic                  PCout,
    input  logic                  MARout,
    input  logic                  IRout,
    input  logic                  Yout,
    input  logic                  MDRout,
    input  logic                  HIout,
    input  logic                  LOout,
    input  logic                  Zhighout,
    input  logic                  Zlowout
);

    logic [DATA_WIDTH-1:0] r_q [16];
    logic [DATA_WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;
    logic [DATA_WIDTH-1:0] bus;
    logic [DATA_WIDTH-1:0] alu_hi, alu_lo;
    logic [DATA_WIDTH-1:0] mdr_d;

    // Reserved inputs are deliberately ignored.
    logic unused_reserved;
    assign unused_reserved = ^{A, RegisterImmediate};

    // Bus mux: assigned lowest priority first so later (higher) sources win.
    always_comb begin
        bus = '0;
        if (MARout)   bus = mar_q;
        if (IRout)    bus = ir_q;
        if (Yout)     bus = y_q;
        if (LOout)    bus = lo_q;
        if (HIout)    bus = hi_q;
        if (Zhighout) bus = zhi_q;
        if (Zlowout)  bus = zlo_q;
        if (MDRout)   bus = mdr_q;
        if (PCout)    bus = pc_q;
        for (int i = 15; i >= 0; i--) begin
            if (Rout[i]) bus = r_q[i];
        end
    end

    assign mdr_d = Read ? Mdatain : bus;

    alu u_alu (
        .a  (y_q),
        .b  (bus),
        .op (ALUop),
        .hi (alu_hi),
        .lo (alu_lo)
    );

    // General-purpose registers R0..R15; clear wins over any load.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 16; i++) begin
            if (clear) begin
                r_q[i] <= '0;
            end else if (Rin[i]) begin
                r_q[i] <= bus;
            end
        end
    end

    // Special registers; each holds unless its own enable is high.
    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            if (PCin)    pc_q  <= bus;
            if (IRin)    ir_q  <= bus;
            if (MARin)   mar_q <= bus;
            if (MDRin)   mdr_q <= mdr_d;
            if (Yin)     y_q   <= bus;
            if (HIin)    hi_q  <= bus;
            if (LOin)    lo_q  <= bus;
            if (Zhighin) zhi_q <= alu_hi;
            if (Zlowin)  zlo_q <= alu_lo;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for datapath; registers are inspected hierarchically.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A, RegisterImmediate, Mdatain;
    logic        Read;
    logic [3:0]  ALUop;
    logic [15:0] Rin, Rout;
    logic        PCin, MARin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin;
    logic        PCout, MARout, IRout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    datapath dut (
        .clock             (clock),
        .clear             (clear),
        .A                 (A),
        .RegisterImmediate (RegisterImmediate),
        .Read              (Read),
        .Mdatain           (Mdatain),
        .ALUop             (ALUop),
        .Rin               (Rin),
        .Rout              (Rout),
        .PCin              (PCin),
        .MARin             (MARin),
        .IRin              (IRin),
        .Yin               (Yin),
        .MDRin             (MDRin),
        .HIin              (HIin),
        .LOin              (LOin),
        .Zhighin           (Zhighin),
        .Zlowin            (Zlowin),
        .PCout             (PCout),
        .MARout            (MARout),
        .IRout             (IRout),
        .Yout              (Yout),
        .MDRout            (MDRout),
        .HIout             (HIout),
        .LOout             (LOout),
        .Zhighout          (Zhighout),
        .Zlowout           (Zlowout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b0; Read = 1'b0; Mdatain = '0; ALUop = 4'd0;
        Rin = '0; Rout = '0;
        PCin = 0; MARin = 0; IRin = 0; Yin = 0; MDRin = 0; HIin = 0; LOin = 0;
        Zhighin = 0; Zlowin = 0;
        PCout = 0; MARout = 0; IRout = 0; Yout = 0; MDRout = 0; HIout = 0; LOout = 0;
        Zhighout = 0; Zlowout = 0;
    endtask

    // One clock: inputs already set; sample 1 ns after the edge, then drop enables.
    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        Read = 1'b1; MDRin = 1'b1; Mdatain = val;
        step();
        MDRout = 1'b1; Rin = 16'(1) << idx;
        step();
    endtask

    task automatic reg_to_y(input int idx);
        Rout = 16'(1) << idx; Yin = 1'b1;
        step();
    endtask

    logic [3:0]  op_tab  [10];
    logic [31:0] exp_tab [10];
    logic [31:0] exp_lo, exp_hi;

    initial begin
        A = 32'hDEAD_BEEF;
        RegisterImmediate = 32'hCAFE_F00D;
        idle();
        #2;

        // Reset
        clear = 1'b1;
        step();
        check_eq("rst_r3",  dut.r_q[3], 32'h0);
        check_eq("rst_pc",  dut.pc_q,   32'h0);
        check_eq("rst_mdr", dut.mdr_q,  32'h0);
        check_eq("rst_zhi", dut.zhi_q,  32'h0);
        check_eq("rst_ir",  dut.ir_q,   32'h0);

        // Div sequence: 0x54 / 6
        load_reg(3, 32'h54);
        check_eq("load_r3", dut.r_q[3], 32'h54);
        load_reg(1, 32'h6);
        reg_to_y(3);
        check_eq("y_from_r3", dut.y_q, 32'h54);
        Rout[1] = 1'b1; ALUop = 4'd12; Zlowin = 1'b1;
        step();
        Zlowout = 1'b1; Rin[3] = 1'b1;
        step();
`ifdef DATAPATH_DIV_EN
        check_eq("div_r3", dut.r_q[3], 32'h0000_000E);
`else
        check_eq("div_r3_off", dut.r_q[3], 32'h0);
`endif

        // Mul: -2 * 3
        load_reg(4, 32'hFFFF_FFFE);
        reg_to_y(4);
        load_reg(5, 32'h3);
        Rout[5] = 1'b1; ALUop = 4'd11; Zlowin = 1'b1; Zhighin = 1'b1;
        step();
        check_eq("mul_zhi", dut.zhi_q, 32'hFFFF_FFFF);
        check_eq("mul_zlo", dut.zlo_q, 32'hFFFF_FFFA);

        // Div by zero: nothing drives the bus, so b = 0
        load_reg(6, 32'h54);
        reg_to_y(6);
        ALUop = 4'd12; Zlowin = 1'b1; Zhighin = 1'b1;
        step();
`ifdef DATAPATH_DIV_EN
        exp_lo = 32'hFFFF_FFFF; exp_hi = 32'h54;
`else
        exp_lo = 32'h0; exp_hi = 32'h0;
`endif
        check_eq("div0_zlo", dut.zlo_q, exp_lo);
        check_eq("div0_zhi", dut.zhi_q, exp_hi);

        // ALU ops with Y = 0x54, bus = R1 = 6
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        exp_tab = '{32'h5A, 32'h4E, 32'h04, 32'h56, 32'h01, 32'h1500, 32'h5000_0001,
                    32'h1500, 32'hFFFF_FFFA, 32'hFFFF_FFF9};
        // Preload ZHI nonzero so the hi = 0 checks can fail.
        reg_to_y(4);
        Rout[5] = 1'b1; ALUop = 4'd11; Zhighin = 1'b1;
        step();
        reg_to_y(6);
        for (int i = 0; i < 10; i++) begin
            Rout[1] = 1'b1; ALUop = op_tab[i]; Zlowin = 1'b1; Zhighin = 1'b1;
            step();
            check_eq($sformatf("op%0d_lo", op_tab[i]), dut.zlo_q, exp_tab[i]);
            check_eq($sformatf("op%0d_hi", op_tab[i]), dut.zhi_q, 32'h0);
        end
        Rout[1] = 1'b1; ALUop = 4'd13; Zlowin = 1'b1;
        step();
        check_eq("op13_lo", dut.zlo_q, 32'h0);

        // Arithmetic vs logical right shift, Y = 0x80000000, bus = 3
        load_reg(8, 32'h8000_0000);
        reg_to_y(8);
        Rout[5] = 1'b1; ALUop = 4'd5; Zlowin = 1'b1;
        step();
        check_eq("shra", dut.zlo_q, 32'hF000_0000);
        Rout[5] = 1'b1; ALUop = 4'd4; Zlowin = 1'b1;
        step();
        check_eq("shr", dut.zlo_q, 32'h1000_0000);

        // Read old value during own load: ZLO <= Y + ZLO, Y = 3
        reg_to_y(5);
        Zlowout = 1'b1; ALUop = 4'd0; Zlowin = 1'b1;
        step();
        check_eq("zlo_self", dut.zlo_q, 32'h1000_0003);

        // MDR source select
        load_reg(2, 32'h1234);
        Read = 1'b1; Mdatain = 32'h0; MDRin = 1'b1;
        step();
        Rout[2] = 1'b1; MDRin = 1'b1; Read = 1'b0; Mdatain = 32'h5555;
        step();
        check_eq("mdr_bus", dut.mdr_q, 32'h1234);
        Rout[2] = 1'b1; MDRin = 1'b1; Read = 1'b1; Mdatain = 32'hABCD;
        step();
        check_eq("mdr_mem", dut.mdr_q, 32'hABCD);

        // Bus priority: R5 beats PC
        load_reg(7, 32'h77);
        Rout[7] = 1'b1; PCin = 1'b1;
        step();
        check_eq("pc_load", dut.pc_q, 32'h77);
        Rout[5] = 1'b1; PCout = 1'b1; Yin = 1'b1;
        step();
        check_eq("prio_r5_pc", dut.y_q, 32'h3);
        PCout = 1'b1; MDRout = 1'b1; Yin = 1'b1;
        step();
        check_eq("prio_pc_mdr", dut.y_q, 32'h77);
        Yin = 1'b1;
        step();
        check_eq("bus_idle", dut.y_q, 32'h0);

        // Clear overrides loads mid-sequence
        load_reg(9, 32'h99);
        clear = 1'b1; Rin[3] = 1'b1; Zlowin = 1'b1; Rout[9] = 1'b1; ALUop = 4'd0;
        step();
        check_eq("clr_r3",  dut.r_q[3], 32'h0);
        check_eq("clr_r9",  dut.r_q[9], 32'h0);
        check_eq("clr_zlo", dut.zlo_q,  32'h0);
        check_eq("clr_pc",  dut.pc_q,   32'h0);
        check_eq("clr_mdr", dut.mdr_q,  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
